// File: rtl/dfx_mbist_pkg.sv
// Shared types for the MBIST enable handshake: FSM state encoding and synchronizer depth.
// Pure declarations, no logic.
package dfx_mbist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } mbist_hs_state_t;

   localparam int MBIST_SYNC_STAGES = 2;

endpackage

// File: rtl/dfx_sync_2ff.sv
// Single-bit flop-chain synchronizer for signals crossing into core_clk; latency STAGES cycles.
// No flow control; the output follows the input after the chain delay.
module dfx_sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dfx_mbist_en_ctrl.sv
// Initiator side of the four-phase MBIST enable handshake, with per-phase timeout and sticky results.
// All outputs are registered; start is accepted only in IDLE and never queued.
module dfx_mbist_en_ctrl
   import dfx_mbist_pkg::*;
#(
   parameter int TO_CYCLES = 8192,
   parameter int CNT_W     = $clog2(TO_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ack_in,
   input  logic pass_in,
   output logic en_out,
   output logic busy,
   output logic done,
   output logic pass,
   output logic timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYCLES - 1);

   mbist_hs_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_s, pass_s;
   logic             pass_d, timeout_d, done_d;

   dfx_sync_2ff #(.STAGES(MBIST_SYNC_STAGES)) u_sync_ack (
      .clk (clk),
      .rst (rst),
      .d   (ack_in),
      .q   (ack_s)
   );

   dfx_sync_2ff #(.STAGES(MBIST_SYNC_STAGES)) u_sync_pass (
      .clk (clk),
      .rst (rst),
      .d   (pass_in),
      .q   (pass_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      pass_d    = pass;
      timeout_d = timeout;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = cnt_q;
            if (start) begin
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               cnt_d     = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            // ack takes priority over a timeout expiring on the same cycle
            if (ack_s) begin
               pass_d  = pass_s;
               cnt_d   = '0;
               state_d = REL;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = REL;
            end
         end
         REL: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX && !timeout) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         en_out  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_out  <= (state_d == REQ);
         busy    <= (state_d != IDLE);
         done    <= done_d;
         pass    <= pass_d;
         timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_dfx_mbist_en_ctrl.sv
// Bench for dfx_mbist_en_ctrl: two instances (default timeout and TO_CYCLES=16) driven by a
// memory-side loopback model; expected results are queued at start and popped on done.
module tb_dfx_mbist_en_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] start, ack_in, pass_in;
   wire  [1:0] en_out, busy, done, pass, timeout;

   always #5 clk = ~clk;

   dfx_mbist_en_ctrl u_dut_nom (
      .clk(clk), .rst(rst), .start(start[0]), .ack_in(ack_in[0]), .pass_in(pass_in[0]),
      .en_out(en_out[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(timeout[0])
   );

   dfx_mbist_en_ctrl #(.TO_CYCLES(16)) u_dut_16 (
      .clk(clk), .rst(rst), .start(start[1]), .ack_in(ack_in[1]), .pass_in(pass_in[1]),
      .en_out(en_out[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(timeout[1])
   );

   typedef struct {
      bit p;
      bit t;
      int lat;
      int sc;
   } exp_t;

   exp_t exp_q[2][$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Outcome from the handshake timing rules: ack_in raised d cycles after en_out is seen high,
   // dropped r cycles after en_out is seen low; ack becomes visible to the FSM two edges later.
   function automatic void model(input int to, input int d, input int r, input bit noack,
                                 input bit stuck, input bit pv, output bit ep, output bit et,
                                 output int lat, output int en_hi);
      if (noack) begin
         ep = 0; et = 1; en_hi = to; lat = to + 1;
      end else if (d + 2 <= to - 1) begin
         ep = pv; en_hi = d + 3;
         if (stuck || r + 3 > to) begin
            et = 1; lat = d + 3 + to;
         end else begin
            et = 0; lat = d + r + 6;
         end
      end else begin
         ep = 0; et = 1; en_hi = to; lat = to + r + 3;
      end
   endfunction

   task automatic run(input int i, input int d, input int r, input bit noack, input bit stuck,
                      input bit pv, input bit poke);
      exp_t e;
      int   to, en_hi_exp, lat, n;
      bit   ep, et;
      to = (i == 0) ? 8192 : 16;
      model(to, d, r, noack, stuck, pv, ep, et, lat, en_hi_exp);
      @(negedge clk);
      start[i] = 1'b1;
      e.p = ep; e.t = et; e.lat = lat; e.sc = cyc + 1;
      exp_q[i].push_back(e);
      @(negedge clk);
      start[i] = 1'b0;
      chk("req_entry", {en_out[i], busy[i], timeout[i], pass[i]}, 4'b1100);
      n = 0;
      for (int t = 0; en_out[i] && t < to + 50; t++) begin
         if (!noack && t == d) begin
            ack_in[i]  = 1'b1;
            pass_in[i] = pv;
         end
         n++;
         @(negedge clk);
      end
      chk("en_high_cycles", n, en_hi_exp);
      if (!noack && !stuck) begin
         repeat (r) @(negedge clk);
         ack_in[i] = 1'b0;
      end
      if (poke) begin
         repeat (2) @(negedge clk);
         start[i] = 1'b1;
         @(negedge clk);
         start[i] = 1'b0;
      end
      for (int t = 0; busy[i] && t < to + 50; t++) @(negedge clk);
      chk("busy_drop", busy[i], 0);
      if (stuck) ack_in[i] = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_after_done", {busy[i], en_out[i]}, 0);
      chk("queue_drained", exp_q[i].size(), 0);
   endtask

   initial begin : monitor
      bit   prev[2];
      exp_t e;
      prev[0] = 0;
      prev[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (prev[i]) begin
               chk("done_width", done[i], 0);
            end else if (done[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk("unexpected_done", exp_q[i].size(), 1);
               end else begin
                  e = exp_q[i].pop_front();
                  chk("pass", pass[i], e.p);
                  chk("timeout", timeout[i], e.t);
                  chk("start_to_done", cyc - e.sc, e.lat);
                  chk("busy_with_done", busy[i], 0);
               end
            end
            prev[i] = done[i];
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1; start = '0; ack_in = '0; pass_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs_nom", {en_out[0], busy[0], done[0], pass[0], timeout[0]}, 0);
      chk("reset_outs_16",  {en_out[1], busy[1], done[1], pass[1], timeout[1]}, 0);
      rst = 1'b0;

      run(0, 20, 0, 0, 0, 1, 0);   // nominal pass
      run(0, 20, 0, 0, 0, 0, 0);   // fail result
      run(1, 0, 0, 1, 0, 0, 0);    // REQ timeout, no ack
      run(1, 3, 0, 0, 1, 1, 1);    // stuck ack, start poked during REL
      run(1, 2, 1, 0, 0, 1, 0);    // new start clears timeout
      run(1, 13, 0, 0, 0, 1, 0);   // ack seen at the last count: ack wins
      run(1, 14, 2, 0, 0, 1, 0);   // ack one cycle late: timeout

      // reset while en_out is high
      @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_req_en", en_out[1], 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_req_reset", {en_out[1], busy[1], done[1], pass[1], timeout[1]}, 0);
      rst = 1'b0;
      run(1, 5, 1, 0, 0, 1, 0);

      for (int k = 0; k < 8; k++)
         run(0, $urandom_range(0, 40), $urandom_range(0, 8), 0, 0, 1'($urandom), 0);
      for (int k = 0; k < 16; k++)
         run(1, $urandom_range(0, 14), $urandom_range(0, 8), 0, 0, 1'($urandom), 0);

      chk("final_queue_nom", exp_q[0].size(), 0);
      chk("final_queue_16", exp_q[1].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
